// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage of the RV32I pipeline. Generates the program
// counter, issues word requests to instruction memory over a request/grant
// handshake, buffers returned words in a 2-entry queue so decode stalls never
// lose an instruction, and redirects on taken branches by flushing the queue
// and discarding every response still in flight.
//
// Ports:
//   clk              pipeline clock, rising edge
//   rst              asynchronous active-low reset
//   imem_req         fetch request valid
//   imem_addr        word address of the request (bits [1:0] always 0)
//   imem_gnt         request accepted this cycle (imem_req & imem_gnt)
//   imem_rvalid      response valid, in order, one per accepted request
//   imem_rdata       instruction word qualified by imem_rvalid
//   branch_taken     redirect request from execute (overrides stall)
//   branch_target    redirect PC, bits [1:0] treated as 0
//   stall            decode cannot take the presented instruction
//   INSTRUCTION_OUT  instruction word to decode (NOP when empty)
//   PC_OUT           address of INSTRUCTION_OUT
//   VALID_OUT        INSTRUCTION_OUT/PC_OUT valid
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic [31:0] INSTRUCTION_OUT,
    output logic [31:0] PC_OUT,
    output logic        VALID_OUT
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    // Held low through reset so no request is issued until the first clock
    // edge after reset release.
    logic        r_run;
    logic [31:0] r_pc;
    // Address of the next response that will be kept. Responses that are not
    // dropped always belong to a consecutive run of requests starting at the
    // last redirect (or reset), so a single counter stands in for a per-request
    // address queue.
    logic [31:0] r_respPc;
    logic [1:0]  r_outstanding;
    logic [1:0]  r_drop;
    logic [1:0]  r_count;
    logic        r_head;
    logic [31:0] r_wordQ [0:1];
    logic [31:0] r_pcQ   [0:1];
    logic [31:0] r_lastPc;

    logic        w_pop;
    logic        w_accept;
    logic        w_write;
    logic        w_tail;
    logic [2:0]  w_credit;
    logic [31:0] w_target;

    // Masking with a constant keeps every target bit in use while forcing
    // word alignment.
    assign w_target = branch_target & ~32'h0000_0003;

    assign VALID_OUT       = (r_count != 2'd0) & ~branch_taken;
    assign INSTRUCTION_OUT = (r_count != 2'd0) ? r_wordQ[r_head] : NOP;
    assign PC_OUT          = (r_count != 2'd0) ? r_pcQ[r_head]   : r_lastPc;

    assign w_pop = VALID_OUT & ~stall;

    // Credit rule: every in-flight request owns a FIFO slot, so a new request
    // is only issued while in-flight plus buffered (after this cycle's pop)
    // stays below the FIFO depth. This is what makes the FIFO overflow-free.
    assign w_credit  = {1'b0, r_outstanding} + {1'b0, r_count} - {2'b00, w_pop};
    assign imem_req  = r_run & ~branch_taken & (w_credit < 3'd2);
    assign imem_addr = r_pc;
    assign w_accept  = imem_req & imem_gnt;

    // With count 0 or 2 the tail slot equals the head slot; with count 1 it
    // is the other slot.
    assign w_tail  = r_head ^ r_count[0];
    assign w_write = imem_rvalid & (r_drop == 2'd0) & ~branch_taken;

    // All fetch state lives in one block. A redirect wins over everything:
    // it empties the FIFO, restarts the PC at the target and marks every
    // response still pending after this cycle for discard.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run         <= 1'b0;
            r_pc          <= RESET_PC;
            r_respPc      <= RESET_PC;
            r_outstanding <= 2'd0;
            r_drop        <= 2'd0;
            r_count       <= 2'd0;
            r_head        <= 1'b0;
            r_wordQ[0]    <= NOP;
            r_wordQ[1]    <= NOP;
            r_pcQ[0]      <= RESET_PC;
            r_pcQ[1]      <= RESET_PC;
            r_lastPc      <= RESET_PC;
        end else begin
            r_run <= 1'b1;
            if (r_count != 2'd0) begin
                r_lastPc <= r_pcQ[r_head];
            end
            if (branch_taken) begin
                // No request can be accepted in a redirect cycle, so the
                // pending count only loses this cycle's response, which is
                // itself discarded.
                r_pc          <= w_target;
                r_respPc      <= w_target;
                r_count       <= 2'd0;
                r_head        <= 1'b0;
                r_outstanding <= r_outstanding - {1'b0, imem_rvalid};
                r_drop        <= r_outstanding - {1'b0, imem_rvalid};
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + 32'd4;
                end
                r_outstanding <= r_outstanding + {1'b0, w_accept} - {1'b0, imem_rvalid};
                if (imem_rvalid && (r_drop != 2'd0)) begin
                    r_drop <= r_drop - 2'd1;
                end
                if (w_write) begin
                    r_wordQ[w_tail] <= imem_rdata;
                    r_pcQ[w_tail]   <= r_respPc;
                    r_respPc        <= r_respPc + 32'd4;
                end
                r_count <= r_count + {1'b0, w_write} - {1'b0, w_pop};
                if (w_pop) begin
                    r_head <= ~r_head;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A behavioural instruction memory answers
// every accepted request with word = addr | 0x13 after a configurable
// latency, in order, one response per cycle. A scoreboard tracks the next
// expected request address and the next expected popped PC; hand-computed
// cycle checks cover reset, latency, stall, redirect and restart after reset.
// A second instance with RESET_PC = FFFF_FFF8 covers address wrap-around.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } memEntry_t;

    logic        clk;
    logic        rst;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pcOut;
    logic        valid;

    logic        req2;
    logic [31:0] addr2;
    logic        rvalid2;
    logic [31:0] rdata2;
    logic [31:0] instr2;
    logic [31:0] pc2;
    logic        valid2;
    logic        prevAccept2;
    logic [31:0] prevAddr2;

    memEntry_t   memQ[$];
    int          cyc;
    int          latMin;
    int          latMax;
    int unsigned gntPct;

    logic [31:0] sReq;
    logic [31:0] sAddr;
    logic [31:0] sValid;
    logic [31:0] sPc;
    logic [31:0] sInstr;

    logic [31:0] expPc;
    logic [31:0] expAddr;
    int          popCount;
    int          n2;
    logic [31:0] pc2Seen [0:2];
    logic [31:0] instr2Seen [0:2];

    int          checks;
    int          errors;

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (req),
        .imem_addr       (addr),
        .imem_gnt        (gnt),
        .imem_rvalid     (rvalid),
        .imem_rdata      (rdata),
        .branch_taken    (branchTaken),
        .branch_target   (branchTarget),
        .stall           (stall),
        .INSTRUCTION_OUT (instr),
        .PC_OUT          (pcOut),
        .VALID_OUT       (valid)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dutWrap (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (req2),
        .imem_addr       (addr2),
        .imem_gnt        (1'b1),
        .imem_rvalid     (rvalid2),
        .imem_rdata      (rdata2),
        .branch_taken    (1'b0),
        .branch_target   (32'h0000_0000),
        .stall           (1'b0),
        .INSTRUCTION_OUT (instr2),
        .PC_OUT          (pc2),
        .VALID_OUT       (valid2)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge: drive memory
    // responses, let outputs settle, sample, score, record accepted requests.
    task automatic applyStimulus();
        memEntry_t e;
        int lat;
        if (rst && (memQ.size() > 0) && (memQ[0].ready <= cyc)) begin
            e      = memQ.pop_front();
            rvalid = 1'b1;
            rdata  = e.addr | 32'h13;
        end else begin
            rvalid = 1'b0;
            rdata  = 32'hDEAD_BEEF;
        end
        gnt     = (gntPct >= 100) ? 1'b1 : ($urandom_range(99) < gntPct);
        rvalid2 = prevAccept2;
        rdata2  = prevAddr2 | 32'h13;
        #1;
        sReq   = 32'(req);
        sAddr  = addr;
        sValid = 32'(valid);
        sPc    = pcOut;
        sInstr = instr;
        if (valid && !stall) begin
            checkOutput("popPc", pcOut, expPc);
            checkOutput("popInstr", instr, expPc | 32'h13);
            expPc = expPc + 32'd4;
            popCount++;
        end
        if (branchTaken) begin
            checkOutput("branchValid", 32'(valid), 32'd0);
            checkOutput("branchReq", 32'(req), 32'd0);
            expPc   = branchTarget & ~32'h3;
            expAddr = branchTarget & ~32'h3;
        end
        if (req && gnt) begin
            checkOutput("reqAddr", addr, expAddr);
            expAddr = expAddr + 32'd4;
            lat = $urandom_range(latMax, latMin);
            e.addr  = addr;
            e.ready = cyc + lat;
            memQ.push_back(e);
            checkOutput("inflightLimit", 32'((memQ.size() <= 2) ? 1 : 0), 32'd1);
        end
        if (valid2 && (n2 < 3)) begin
            pc2Seen[n2]    = pc2;
            instr2Seen[n2] = instr2;
            n2++;
        end
        prevAccept2 = req2 & rst;
        prevAddr2   = addr2;
        @(negedge clk);
        cyc++;
    endtask

    // Holds reset for two cycles, checks the reset outputs, then releases
    // reset at a falling edge so the next rising edge is the release edge.
    task automatic resetDut();
        rst         = 1'b0;
        stall       = 1'b0;
        branchTaken = 1'b0;
        memQ.delete();
        prevAccept2 = 1'b0;
        repeat (2) applyStimulus();
        checkOutput("rstReq", sReq, 32'd0);
        checkOutput("rstValid", sValid, 32'd0);
        checkOutput("rstInstr", sInstr, 32'h0000_0013);
        checkOutput("rstPc", sPc, 32'h0000_0000);
        expPc   = 32'h0;
        expAddr = 32'h0;
        rst     = 1'b1;
    endtask

    // Main directed sequence.
    initial begin
        rst          = 1'b1;
        gnt          = 1'b1;
        rvalid       = 1'b0;
        rdata        = 32'h0;
        rvalid2      = 1'b0;
        rdata2       = 32'h0;
        prevAccept2  = 1'b0;
        prevAddr2    = 32'h0;
        branchTaken  = 1'b0;
        branchTarget = 32'h0;
        stall        = 1'b0;
        cyc          = 0;
        latMin       = 1;
        latMax       = 1;
        gntPct       = 100;
        expPc        = 32'h0;
        expAddr      = 32'h0;
        popCount     = 0;
        n2           = 0;
        checks       = 0;
        errors       = 0;
        for (int i = 0; i < 3; i++) begin
            pc2Seen[i]    = 32'h0000_0001;
            instr2Seen[i] = 32'h0000_0001;
        end
        #1 rst = 1'b0;
        @(negedge clk);

        // Reset, then streaming fetch with a 1-cycle memory.
        resetDut();
        applyStimulus();
        checkOutput("preReleaseReq", sReq, 32'd0);
        applyStimulus();
        checkOutput("c1Req", sReq, 32'd1);
        checkOutput("c1Addr", sAddr, 32'h0);
        applyStimulus();
        checkOutput("c2Valid", sValid, 32'd0);
        checkOutput("c2Addr", sAddr, 32'h4);
        applyStimulus();
        checkOutput("c3Valid", sValid, 32'd1);
        checkOutput("c3Pc", sPc, 32'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("streamValid", sValid, 32'd1);
        end

        // Wrap-around instance must present FFFF_FFF8, FFFF_FFFC, 0.
        checkOutput("wrapPc0", pc2Seen[0], 32'hFFFF_FFF8);
        checkOutput("wrapPc1", pc2Seen[1], 32'hFFFF_FFFC);
        checkOutput("wrapPc2", pc2Seen[2], 32'h0000_0000);
        checkOutput("wrapInstr0", instr2Seen[0], 32'hFFFF_FFFB);
        checkOutput("wrapInstr1", instr2Seen[1], 32'hFFFF_FFFF);
        checkOutput("wrapInstr2", instr2Seen[2], 32'h0000_0013);

        // Decode stall: head held, requests stop, then resume with no bubble.
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("stallPc", sPc, 32'd24);
            checkOutput("stallValid", sValid, 32'd1);
            checkOutput("stallReq", sReq, 32'd0);
        end
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checkOutput("releaseValid", sValid, 32'd1);
        end

        // Redirect from a busy stream, then a second redirect while two
        // responses are in flight (one returning in the redirect cycle).
        branchTaken  = 1'b1;
        branchTarget = 32'h0000_0200;
        applyStimulus();
        branchTaken = 1'b0;
        latMin      = 2;
        latMax      = 2;
        applyStimulus();
        checkOutput("redirAddr", sAddr, 32'h0000_0200);
        applyStimulus();
        checkOutput("redirInflight", 32'(memQ.size()), 32'd2);
        branchTaken  = 1'b1;
        branchTarget = 32'h0000_0101;
        applyStimulus();
        branchTaken = 1'b0;
        latMin      = 1;
        latMax      = 1;
        applyStimulus();
        checkOutput("r1Valid", sValid, 32'd0);
        checkOutput("r1Req", sReq, 32'd1);
        checkOutput("r1Addr", sAddr, 32'h0000_0100);
        applyStimulus();
        checkOutput("r2Valid", sValid, 32'd0);
        applyStimulus();
        checkOutput("r3Valid", sValid, 32'd1);
        checkOutput("r3Pc", sPc, 32'h0000_0100);

        // Random grant, latency 1..3, random stall and occasional redirects.
        begin
            int startPops;
            startPops = popCount;
            gntPct    = 70;
            latMin    = 1;
            latMax    = 3;
            for (int i = 0; i < 300; i++) begin
                stall = ($urandom_range(99) < 25);
                if ($urandom_range(99) < 3) begin
                    branchTaken  = 1'b1;
                    branchTarget = $urandom & 32'h0000_FFFF;
                end else begin
                    branchTaken = 1'b0;
                end
                applyStimulus();
            end
            branchTaken = 1'b0;
            stall       = 1'b0;
            gntPct      = 100;
            latMin      = 1;
            latMax      = 1;
            checkOutput("randProgress", 32'(((popCount - startPops) > 30) ? 1 : 0), 32'd1);
        end

        // Fill the queue under stall, then assert reset mid-cycle.
        for (int i = 0; i < 6; i++) applyStimulus();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("fullReq", sReq, 32'd0);
        checkOutput("fullValid", sValid, 32'd1);
        #3 rst = 1'b0;
        #1;
        checkOutput("asyncValid", 32'(valid), 32'd0);
        checkOutput("asyncInstr", instr, 32'h0000_0013);
        checkOutput("asyncPc", pcOut, 32'h0000_0000);
        checkOutput("asyncReq", 32'(req), 32'd0);
        @(negedge clk);
        resetDut();
        applyStimulus();
        applyStimulus();
        checkOutput("restartReq", sReq, 32'd1);
        checkOutput("restartAddr", sAddr, 32'h0);
        applyStimulus();
        applyStimulus();
        checkOutput("restartValid", sValid, 32'd1);
        checkOutput("restartPc", sPc, 32'h0);
        applyStimulus();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
